// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family:
// mode constants, step direction and bound arithmetic helpers.
package counter_pkg;

  localparam int CNT_SATURATE = 0;
  localparam int CNT_WRAP     = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  function automatic int unsigned range_size(input int unsigned min_val,
                                             input int unsigned max_val);
    return max_val - min_val + 32'd1;
  endfunction

  function automatic int unsigned clamp_val(input int unsigned value,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-value calculator for one step in a given direction,
// handling step clamping, bound detection and saturate/wrap correction.
module updown_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 31
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_step,
  input  cnt_dir_e         i_dir,
  input  logic             i_wrap,
  output logic [WIDTH-1:0] o_next,
  output logic             o_event
);

  // Two guard bits: one for the carry, one so MIN + step never overflows.
  localparam int XW = WIDTH + 2;
  localparam logic [XW-1:0] RANGE_X = XW'(range_size(32'(MIN_VAL), 32'(MAX_VAL)));
  localparam logic [XW-1:0] MIN_X   = XW'(MIN_VAL);
  localparam logic [XW-1:0] MAX_X   = XW'(MAX_VAL);

  logic [XW-1:0] w_count_x;
  logic [XW-1:0] w_step_raw_x;
  logic [XW-1:0] w_step_x;
  logic [XW-1:0] w_sum_x;
  logic [XW-1:0] w_floor_x;

  assign w_count_x    = {2'b00, i_count};
  assign w_step_raw_x = {2'b00, i_step};
  assign w_step_x     = (w_step_raw_x > RANGE_X) ? RANGE_X : w_step_raw_x;
  assign w_sum_x      = w_count_x + w_step_x;
  // A down-step underflows exactly when count - step < MIN, i.e. count < MIN + step.
  assign w_floor_x    = MIN_X + w_step_x;

  always_comb begin
    o_next  = i_count;
    o_event = 1'b0;
    case (i_dir)
      DIR_UP: begin
        if (w_sum_x > MAX_X) begin
          o_event = 1'b1;
          if (i_wrap) begin
            o_next = WIDTH'(w_sum_x - RANGE_X);
          end else begin
            o_next = WIDTH'(MAX_X);
          end
        end else begin
          o_next = WIDTH'(w_sum_x);
        end
      end
      DIR_DOWN: begin
        if (w_count_x < w_floor_x) begin
          o_event = 1'b1;
          if (i_wrap) begin
            o_next = WIDTH'(w_count_x + RANGE_X - w_step_x);
          end else begin
            o_next = WIDTH'(MIN_X);
          end
        end else begin
          o_next = WIDTH'(w_count_x - w_step_x);
        end
      end
      default: begin
        o_next  = i_count;
        o_event = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_param.sv
// Bounded up/down counter with load, enable, programmable step,
// saturate/wrap mode and registered overflow/underflow pulses.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int WRAP    = CNT_SATURATE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] STEP,
  output logic [WIDTH-1:0] counter,
  output logic             High,
  output logic             Low,
  output logic             Ovf,
  output logic             Unf
);

  generate
    if (WIDTH < 2 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 2**WIDTH - 1 ||
        (WRAP != CNT_SATURATE && WRAP != CNT_WRAP)) begin : g_bad_params
      $fatal(1, "updown_counter_param: illegal WIDTH/MIN_VAL/MAX_VAL/WRAP");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic             WRAP_EN = 1'(WRAP == CNT_WRAP);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_calc_next;
  logic             w_calc_event;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_ovf;
  logic             w_next_unf;
  cnt_dir_e         w_dir;

  assign w_load_val = WIDTH'(clamp_val(32'(IN), 32'(MIN_VAL), 32'(MAX_VAL)));
  // Down outranks Up, so a simultaneous request evaluates the down-step.
  assign w_dir      = Down ? DIR_DOWN : DIR_UP;

  updown_next_calc #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .i_count (r_count),
    .i_step  (STEP),
    .i_dir   (w_dir),
    .i_wrap  (WRAP_EN),
    .o_next  (w_calc_next),
    .o_event (w_calc_event)
  );

  always_comb begin
    w_next_count = r_count;
    w_next_ovf   = 1'b0;
    w_next_unf   = 1'b0;
    if (Load) begin
      w_next_count = w_load_val;
    end else if (EN && (Up || Down)) begin
      w_next_count = w_calc_next;
      w_next_ovf   = w_calc_event && !Down;
      w_next_unf   = w_calc_event && Down;
    end else begin
      w_next_count = r_count;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= MIN_W;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_ovf   <= w_next_ovf;
      r_unf   <= w_next_unf;
    end
  end

  assign counter = r_count;
  assign Ovf     = r_ovf;
  assign Unf     = r_unf;
  assign High    = (r_count == MAX_W);
  assign Low     = (r_count == MIN_W);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus
// stream; a spec-level integer model is compared every cycle plus literal checks.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i, load_i, up_i, down_i;
  logic [4:0] in_i, step_i;

  logic [4:0] cnt_o [3];
  logic       hi_o  [3];
  logic       lo_o  [3];
  logic       ovf_o [3];
  logic       unf_o [3];

  int lo_c [3] = '{2, 2, 0};
  int hi_c [3] = '{29, 29, 31};
  bit wr_c [3] = '{1'b0, 1'b1, 1'b0};

  int m_cnt [3];
  bit m_ovf [3];
  bit m_unf [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(5), .MIN_VAL(2), .MAX_VAL(29), .WRAP(0)) u_sat (
    .CLK(clk), .RST(rst_n), .EN(en_i), .Load(load_i), .Up(up_i), .Down(down_i),
    .IN(in_i), .STEP(step_i), .counter(cnt_o[0]), .High(hi_o[0]), .Low(lo_o[0]),
    .Ovf(ovf_o[0]), .Unf(unf_o[0]));

  updown_counter_param #(.WIDTH(5), .MIN_VAL(2), .MAX_VAL(29), .WRAP(1)) u_wrap (
    .CLK(clk), .RST(rst_n), .EN(en_i), .Load(load_i), .Up(up_i), .Down(down_i),
    .IN(in_i), .STEP(step_i), .counter(cnt_o[1]), .High(hi_o[1]), .Low(lo_o[1]),
    .Ovf(ovf_o[1]), .Unf(unf_o[1]));

  updown_counter_param #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(31), .WRAP(0)) u_full (
    .CLK(clk), .RST(rst_n), .EN(en_i), .Load(load_i), .Up(up_i), .Down(down_i),
    .IN(in_i), .STEP(step_i), .counter(cnt_o[2]), .High(hi_o[2]), .Low(lo_o[2]),
    .Ovf(ovf_o[2]), .Unf(unf_o[2]));

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d got=%0d expected=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic void model_step(input int lo, input int hi, input bit wrap,
                                     input int cur, output int n, output bit o,
                                     output bit u);
    int range, s, raw, vin;
    range = hi - lo + 1;
    s     = (int'(step_i) > range) ? range : int'(step_i);
    vin   = int'(in_i);
    n = cur;
    o = 1'b0;
    u = 1'b0;
    if (load_i) begin
      n = (vin < lo) ? lo : ((vin > hi) ? hi : vin);
    end else if (en_i && down_i) begin
      raw = cur - s;
      if (raw < lo) begin
        u = 1'b1;
        n = wrap ? raw + range : lo;
      end else begin
        n = raw;
      end
    end else if (en_i && up_i) begin
      raw = cur + s;
      if (raw > hi) begin
        o = 1'b1;
        n = wrap ? raw - range : hi;
      end else begin
        n = raw;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k] <= lo_c[k];
        m_ovf[k] <= 1'b0;
        m_unf[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int n;
        bit o, u;
        model_step(lo_c[k], hi_c[k], wr_c[k], m_cnt[k], n, o, u);
        m_cnt[k] <= n;
        m_ovf[k] <= o;
        m_unf[k] <= u;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check("model_count", k, 32'(cnt_o[k]), 32'(m_cnt[k]));
      check("model_high",  k, 32'(hi_o[k]),  32'(m_cnt[k] == hi_c[k]));
      check("model_low",   k, 32'(lo_o[k]),  32'(m_cnt[k] == lo_c[k]));
      check("model_ovf",   k, 32'(ovf_o[k]), 32'(m_ovf[k]));
      check("model_unf",   k, 32'(unf_o[k]), 32'(m_unf[k]));
    end
  end

  task automatic drive(input logic ld, input logic e, input logic u, input logic d,
                       input int v, input int st);
    load_i = ld;
    en_i   = e;
    up_i   = u;
    down_i = d;
    in_i   = 5'(v);
    step_i = 5'(st);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    check("reset_count", 0, 32'(cnt_o[0]), 32'd2);
    check("reset_low",   0, 32'(lo_o[0]),  32'd1);
    check("reset_high",  0, 32'(hi_o[0]),  32'd0);
    check("reset_count", 2, 32'(cnt_o[2]), 32'd0);
    tick();
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 31, 0); tick();
    check("load_clamp_hi", 0, 32'(cnt_o[0]), 32'd29);
    check("load_high",     0, 32'(hi_o[0]),  32'd1);
    check("load_full",     2, 32'(cnt_o[2]), 32'd31);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); tick();
    check("load_clamp_lo_en0", 0, 32'(cnt_o[0]), 32'd2);
    check("load_low",          0, 32'(lo_o[0]),  32'd1);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 27, 3); tick();
    check("load_beats_up", 0, 32'(cnt_o[0]), 32'd27);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 3); tick();
    check("sat_up",      0, 32'(cnt_o[0]), 32'd29);
    check("sat_ovf",     0, 32'(ovf_o[0]), 32'd1);
    check("wrap_up_27p3", 1, 32'(cnt_o[1]), 32'd2);
    tick();
    check("sat_hold",     0, 32'(cnt_o[0]), 32'd29);
    check("sat_ovf_again", 0, 32'(ovf_o[0]), 32'd1);
    check("wrap_no_ovf",  1, 32'(ovf_o[1]), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 3); tick();
    check("ovf_drops", 0, 32'(ovf_o[0]), 32'd0);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 27, 5); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 5); tick();
    check("wrap_up",  1, 32'(cnt_o[1]), 32'd4);
    check("wrap_ovf", 1, 32'(ovf_o[1]), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 4); tick();
    check("wrap_down",  1, 32'(cnt_o[1]), 32'd27);
    check("wrap_unf",   1, 32'(unf_o[1]), 32'd1);
    check("sat_down",   0, 32'(cnt_o[0]), 32'd2);
    check("sat_unf",    0, 32'(unf_o[0]), 32'd1);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 10, 0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 1); tick();
    check("down_beats_up", 0, 32'(cnt_o[0]), 32'd9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6, 1); tick();
    check("load_up", 0, 32'(cnt_o[0]), 32'd6);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1); tick();
    check("en0_hold", 0, 32'(cnt_o[0]), 32'd6);
    check("en0_ovf",  0, 32'(ovf_o[0]), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); tick();
    check("step0_hold", 0, 32'(cnt_o[0]), 32'd6);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 31); tick();
    check("big_step_sat",  0, 32'(cnt_o[0]), 32'd29);
    check("big_step_wrap", 1, 32'(cnt_o[1]), 32'd6);
    check("big_step_ovf",  1, 32'(ovf_o[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_clears_ovf", 0, 32'(ovf_o[0]), 32'd0);
    check("rst_count",      0, 32'(cnt_o[0]), 32'd2);
    tick();
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 17, 0); tick();
    check("pre_reset", 0, 32'(cnt_o[0]), 32'd17);
    #2 rst_n = 1'b0;
    #1;
    check("midcount_rst_count", 0, 32'(cnt_o[0]), 32'd2);
    check("midcount_rst_low",   0, 32'(lo_o[0]),  32'd1);
    check("midcount_rst_high",  0, 32'(hi_o[0]),  32'd0);
    check("midcount_rst_unf",   0, 32'(unf_o[0]), 32'd0);
    tick();
    rst_n = 1'b1;

    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 30) check("sweep_up_30", 2, 32'({hi_o[2], cnt_o[2]}), 32'd30);
      if (i == 31) check("sweep_up_31", 2, 32'({hi_o[2], cnt_o[2]}), 32'd63);
    end
    check("sweep_up_end", 2, 32'({hi_o[2], cnt_o[2]}), 32'd63);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 30) check("sweep_dn_30", 2, 32'({lo_o[2], cnt_o[2]}), 32'd1);
      if (i == 31) check("sweep_dn_31", 2, 32'({lo_o[2], cnt_o[2]}), 32'd32);
    end
    check("sweep_dn_end", 2, 32'({lo_o[2], cnt_o[2]}), 32'd32);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
